// File: rtl/tao_decode_stage.sv
// RV32I/RV32E decode stage: combinational decode of the incoming word into a control packet,
// held in a 2-entry elastic buffer (output register + skid register) so i_ready is a flop.
module tao_decode_stage #(
  parameter int REG_AW = 4,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [XLEN-1:0]   o_pc,
  output logic              o_rs1en,
  output logic              o_rs2en,
  output logic              o_rdwen,
  output logic [REG_AW-1:0] o_rs1idx,
  output logic [REG_AW-1:0] o_rs2idx,
  output logic [REG_AW-1:0] o_rdidx,
  output logic [31:0]       o_imm,
  output logic [3:0]        o_alu_op,
  output logic [1:0]        o_op1_sel,
  output logic [1:0]        o_op2_sel,
  output logic              o_branch,
  output logic [2:0]        o_br_type,
  output logic              o_jump,
  output logic              o_jalr,
  output logic              o_load,
  output logic              o_store,
  output logic [1:0]        o_mem_size,
  output logic              o_mem_uns,
  output logic              o_ecall,
  output logic              o_ebreak,
  output logic              o_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              rs1en;
    logic              rs2en;
    logic              rdwen;
    logic [REG_AW-1:0] rs1idx;
    logic [REG_AW-1:0] rs2idx;
    logic [REG_AW-1:0] rdidx;
    logic [31:0]       imm;
    logic [3:0]        alu_op;
    logic [1:0]        op1_sel;
    logic [1:0]        op2_sel;
    logic              branch;
    logic [2:0]        br_type;
    logic              jump;
    logic              jalr;
    logic              load;
    logic              store;
    logic [1:0]        mem_size;
    logic              mem_uns;
    logic              ecall;
    logic              ebreak;
    logic              illegal;
  } pkt_t;

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        ill;
  pkt_t        dec;

  assign opcode = i_inst[6:0];
  assign f3     = i_inst[14:12];
  assign f7     = i_inst[31:25];
  assign rd_f   = i_inst[11:7];
  assign rs1_f  = i_inst[19:15];
  assign rs2_f  = i_inst[24:20];
  assign imm_i  = {{21{i_inst[31]}}, i_inst[30:20]};
  assign imm_s  = {{21{i_inst[31]}}, i_inst[30:25], i_inst[11:7]};
  assign imm_b  = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u  = {i_inst[31:12], 12'b0};
  assign imm_j  = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.rdwen = 1'b1; dec.imm = imm_u;
        dec.op1_sel = OP1_ZERO; dec.op2_sel = OP2_IMM;
      end
      OPC_AUIPC: begin
        dec.rdwen = 1'b1; dec.imm = imm_u;
        dec.op1_sel = OP1_PC; dec.op2_sel = OP2_IMM;
      end
      OPC_JAL: begin
        dec.rdwen = 1'b1; dec.imm = imm_j; dec.jump = 1'b1;
        dec.op1_sel = OP1_PC; dec.op2_sel = OP2_FOUR;
      end
      OPC_JALR: begin
        dec.rs1en = 1'b1; dec.rdwen = 1'b1; dec.imm = imm_i;
        dec.jump = 1'b1; dec.jalr = 1'b1;
        dec.op1_sel = OP1_PC; dec.op2_sel = OP2_FOUR;
        ill = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.rs1en = 1'b1; dec.rs2en = 1'b1; dec.imm = imm_b;
        dec.alu_op = ALU_SUB; dec.branch = 1'b1; dec.br_type = f3;
        ill = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec.rs1en = 1'b1; dec.rdwen = 1'b1; dec.imm = imm_i; dec.op2_sel = OP2_IMM;
        dec.load = 1'b1; dec.mem_size = f3[1:0]; dec.mem_uns = f3[2];
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.rs1en = 1'b1; dec.rs2en = 1'b1; dec.imm = imm_s; dec.op2_sel = OP2_IMM;
        dec.store = 1'b1; dec.mem_size = f3[1:0];
        ill = (f3 >= 3'b011);
      end
      OPC_OPIMM: begin
        dec.rs1en = 1'b1; dec.rdwen = 1'b1; dec.imm = imm_i; dec.op2_sel = OP2_IMM;
        dec.alu_op = alu_sel(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)
          ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_OP: begin
        dec.rs1en = 1'b1; dec.rs2en = 1'b1; dec.rdwen = 1'b1;
        dec.alu_op = alu_sel(f3, f7[5]);
        ill = (f7 != 7'b0000000) &&
              !((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_FENCE: dec = '0;
      OPC_SYSTEM: begin
        if (i_inst == 32'h0000_0073)      dec.ecall  = 1'b1;
        else if (i_inst == 32'h0010_0073) dec.ebreak = 1'b1;
        else                              ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // RV32E has only x0-x15: any index actually used with bit 4 set is an exception
    if (REG_AW == 4)
      ill = ill | (dec.rs1en & rs1_f[4]) | (dec.rs2en & rs2_f[4]) | (dec.rdwen & rd_f[4]);
    if (rd_f == 5'd0)
      dec.rdwen = 1'b0;
    dec.rs1idx = rs1_f[REG_AW-1:0];
    dec.rs2idx = rs2_f[REG_AW-1:0];
    dec.rdidx  = rd_f[REG_AW-1:0];
    if (ill) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
    dec.pc = i_pc;
  end

  pkt_t out_q, out_d, skid_q, skid_d;
  logic vld_q, vld_d, skid_vld_q, skid_vld_d;
  logic accept, load_out;

  assign i_ready  = !skid_vld_q;
  assign accept   = i_valid & i_ready;
  assign load_out = !vld_q | o_ready;

  always_comb begin
    out_d      = out_q;
    vld_d      = vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (i_flush) begin
      vld_d      = 1'b0;
      skid_vld_d = 1'b0;
    end else if (load_out) begin
      // skid holds the older instruction, and i_ready is low whenever it is full
      if (skid_vld_q) begin
        out_d      = skid_q;
        vld_d      = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d = dec;
        vld_d = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  // decode -> packet register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      vld_q      <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      vld_q      <= vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign o_valid    = vld_q;
  assign o_pc       = out_q.pc;
  assign o_rs1en    = out_q.rs1en;
  assign o_rs2en    = out_q.rs2en;
  assign o_rdwen    = out_q.rdwen;
  assign o_rs1idx   = out_q.rs1idx;
  assign o_rs2idx   = out_q.rs2idx;
  assign o_rdidx    = out_q.rdidx;
  assign o_imm      = out_q.imm;
  assign o_alu_op   = out_q.alu_op;
  assign o_op1_sel  = out_q.op1_sel;
  assign o_op2_sel  = out_q.op2_sel;
  assign o_branch   = out_q.branch;
  assign o_br_type  = out_q.br_type;
  assign o_jump     = out_q.jump;
  assign o_jalr     = out_q.jalr;
  assign o_load     = out_q.load;
  assign o_store    = out_q.store;
  assign o_mem_size = out_q.mem_size;
  assign o_mem_uns  = out_q.mem_uns;
  assign o_ecall    = out_q.ecall;
  assign o_ebreak   = out_q.ebreak;
  assign o_illegal  = out_q.illegal;

endmodule

// File: tb/tb_tao_decode_stage.sv
// Bench for tao_decode_stage: RV32E and RV32I instances share one stimulus stream; each has
// its own expected-packet queue filled at input handshakes and drained by an output monitor.
module tb_tao_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        rs1en;
    logic        rs2en;
    logic        rdwen;
    logic [4:0]  rs1idx;
    logic [4:0]  rs2idx;
    logic [4:0]  rdidx;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  op1_sel;
    logic [1:0]  op2_sel;
    logic        branch;
    logic [2:0]  br_type;
    logic        jump;
    logic        jalr;
    logic        load;
    logic        store;
    logic [1:0]  mem_size;
    logic        mem_uns;
    logic        ecall;
    logic        ebreak;
    logic        illegal;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        o_ready;

  logic        i_ready4, o_valid4, o_rs1en4, o_rs2en4, o_rdwen4, o_branch4, o_jump4, o_jalr4;
  logic        o_load4, o_store4, o_mem_uns4, o_ecall4, o_ebreak4, o_illegal4;
  logic [31:0] o_pc4, o_imm4;
  logic [3:0]  o_rs1idx4, o_rs2idx4, o_rdidx4, o_alu_op4;
  logic [1:0]  o_op1_sel4, o_op2_sel4, o_mem_size4;
  logic [2:0]  o_br_type4;

  logic        i_ready5, o_valid5, o_rs1en5, o_rs2en5, o_rdwen5, o_branch5, o_jump5, o_jalr5;
  logic        o_load5, o_store5, o_mem_uns5, o_ecall5, o_ebreak5, o_illegal5;
  logic [31:0] o_pc5, o_imm5;
  logic [4:0]  o_rs1idx5, o_rs2idx5, o_rdidx5;
  logic [3:0]  o_alu_op5;
  logic [1:0]  o_op1_sel5, o_op2_sel5, o_mem_size5;
  logic [2:0]  o_br_type5;

  always #5 clk = ~clk;

  tao_decode_stage #(.REG_AW(4), .XLEN(32)) dut4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready4), .i_inst(i_inst),
    .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid4), .o_ready(o_ready), .o_pc(o_pc4),
    .o_rs1en(o_rs1en4), .o_rs2en(o_rs2en4), .o_rdwen(o_rdwen4), .o_rs1idx(o_rs1idx4),
    .o_rs2idx(o_rs2idx4), .o_rdidx(o_rdidx4), .o_imm(o_imm4), .o_alu_op(o_alu_op4),
    .o_op1_sel(o_op1_sel4), .o_op2_sel(o_op2_sel4), .o_branch(o_branch4),
    .o_br_type(o_br_type4), .o_jump(o_jump4), .o_jalr(o_jalr4), .o_load(o_load4),
    .o_store(o_store4), .o_mem_size(o_mem_size4), .o_mem_uns(o_mem_uns4),
    .o_ecall(o_ecall4), .o_ebreak(o_ebreak4), .o_illegal(o_illegal4));

  tao_decode_stage #(.REG_AW(5), .XLEN(32)) dut5 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready5), .i_inst(i_inst),
    .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid5), .o_ready(o_ready), .o_pc(o_pc5),
    .o_rs1en(o_rs1en5), .o_rs2en(o_rs2en5), .o_rdwen(o_rdwen5), .o_rs1idx(o_rs1idx5),
    .o_rs2idx(o_rs2idx5), .o_rdidx(o_rdidx5), .o_imm(o_imm5), .o_alu_op(o_alu_op5),
    .o_op1_sel(o_op1_sel5), .o_op2_sel(o_op2_sel5), .o_branch(o_branch5),
    .o_br_type(o_br_type5), .o_jump(o_jump5), .o_jalr(o_jalr5), .o_load(o_load5),
    .o_store(o_store5), .o_mem_size(o_mem_size5), .o_mem_uns(o_mem_uns5),
    .o_ecall(o_ecall5), .o_ebreak(o_ebreak5), .o_illegal(o_illegal5));

  pkt_t act4, act5;
  always_comb begin
    act4 = '0;
    act4.pc = o_pc4; act4.rs1en = o_rs1en4; act4.rs2en = o_rs2en4; act4.rdwen = o_rdwen4;
    act4.rs1idx = {1'b0, o_rs1idx4}; act4.rs2idx = {1'b0, o_rs2idx4};
    act4.rdidx = {1'b0, o_rdidx4}; act4.imm = o_imm4; act4.alu_op = o_alu_op4;
    act4.op1_sel = o_op1_sel4; act4.op2_sel = o_op2_sel4; act4.branch = o_branch4;
    act4.br_type = o_br_type4; act4.jump = o_jump4; act4.jalr = o_jalr4;
    act4.load = o_load4; act4.store = o_store4; act4.mem_size = o_mem_size4;
    act4.mem_uns = o_mem_uns4; act4.ecall = o_ecall4; act4.ebreak = o_ebreak4;
    act4.illegal = o_illegal4;
  end
  always_comb begin
    act5 = '0;
    act5.pc = o_pc5; act5.rs1en = o_rs1en5; act5.rs2en = o_rs2en5; act5.rdwen = o_rdwen5;
    act5.rs1idx = o_rs1idx5; act5.rs2idx = o_rs2idx5; act5.rdidx = o_rdidx5;
    act5.imm = o_imm5; act5.alu_op = o_alu_op5; act5.op1_sel = o_op1_sel5;
    act5.op2_sel = o_op2_sel5; act5.branch = o_branch5; act5.br_type = o_br_type5;
    act5.jump = o_jump5; act5.jalr = o_jalr5; act5.load = o_load5; act5.store = o_store5;
    act5.mem_size = o_mem_size5; act5.mem_uns = o_mem_uns5; act5.ecall = o_ecall5;
    act5.ebreak = o_ebreak5; act5.illegal = o_illegal5;
  end

  int n_chk  = 0;
  int n_fail = 0;
  pkt_t q4[$];
  pkt_t q5[$];

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input bit alt);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return tbl[f3];
  endfunction

  // Reference decode written from the instruction-set rules, immediates via signed shifts
  function automatic pkt_t ref_dec(input logic [31:0] in, input logic [31:0] pc, input int aw);
    pkt_t p;
    bit ok;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, r1, r2;
    logic [31:0] iimm, simm, bimm, uimm, jimm;
    p = '0; ok = 1'b1;
    f3 = in[14:12]; f7 = in[31:25]; rd = in[11:7]; r1 = in[19:15]; r2 = in[24:20];
    iimm = 32'($signed(in) >>> 20);
    simm = 32'($signed({in[31:25], in[11:7], 20'b0}) >>> 20);
    bimm = 32'($signed({in[31], in[7], in[30:25], in[11:8], 20'b0}) >>> 19);
    jimm = 32'($signed({in[31], in[19:12], in[20], in[30:21], 12'b0}) >>> 11);
    uimm = in & 32'hffff_f000;
    case (in[6:0])
      7'h37: begin p.rdwen = 1; p.imm = uimm; p.op1_sel = 2; p.op2_sel = 1; end
      7'h17: begin p.rdwen = 1; p.imm = uimm; p.op1_sel = 1; p.op2_sel = 1; end
      7'h6f: begin p.rdwen = 1; p.imm = jimm; p.op1_sel = 1; p.op2_sel = 2; p.jump = 1; end
      7'h67: begin
        ok = (f3 == 0); p.rs1en = 1; p.rdwen = 1; p.imm = iimm;
        p.op1_sel = 1; p.op2_sel = 2; p.jump = 1; p.jalr = 1;
      end
      7'h63: begin
        ok = !(f3 == 2 || f3 == 3); p.rs1en = 1; p.rs2en = 1; p.imm = bimm;
        p.alu_op = 1; p.branch = 1; p.br_type = f3;
      end
      7'h03: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        p.rs1en = 1; p.rdwen = 1; p.imm = iimm; p.op2_sel = 1; p.load = 1;
        p.mem_size = f3[1:0]; p.mem_uns = f3[2];
      end
      7'h23: begin
        ok = (f3 < 3); p.rs1en = 1; p.rs2en = 1; p.imm = simm; p.op2_sel = 1;
        p.store = 1; p.mem_size = f3[1:0];
      end
      7'h13: begin
        p.rs1en = 1; p.rdwen = 1; p.imm = iimm; p.op2_sel = 1;
        p.alu_op = ref_alu(f3, f3 == 5 && f7 == 7'h20);
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      end
      7'h33: begin
        p.rs1en = 1; p.rs2en = 1; p.rdwen = 1;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        p.alu_op = ref_alu(f3, f7 == 7'h20);
      end
      7'h0f: ok = 1;
      7'h73: begin
        if (in == 32'h0000_0073) p.ecall = 1;
        else if (in == 32'h0010_0073) p.ebreak = 1;
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (aw == 4 && ((p.rs1en && r1 > 15) || (p.rs2en && r2 > 15) || (p.rdwen && rd > 15))) ok = 0;
    if (rd == 0) p.rdwen = 0;
    p.rs1idx = (aw == 4) ? r1 % 16 : r1;
    p.rs2idx = (aw == 4) ? r2 % 16 : r2;
    p.rdidx  = (aw == 4) ? rd % 16 : rd;
    if (!ok) begin p = '0; p.illegal = 1; end
    p.pc = pc;
    return p;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 11))
      0: ;
      1: r[6:0] = 7'h37;
      2: r[6:0] = 7'h17;
      3: r[6:0] = 7'h6f;
      4: r[6:0] = 7'h67;
      5: r[6:0] = 7'h63;
      6: r[6:0] = 7'h03;
      7: r[6:0] = 7'h23;
      8: r[6:0] = 7'h13;
      9: r[6:0] = 7'h33;
      10: r[6:0] = 7'h0f;
      default: r = ($urandom_range(0, 2) == 0) ? {r[31:7], 7'h73} :
                   (($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0010_0073);
    endcase
    if ($urandom_range(0, 1) == 0) r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    if ($urandom_range(0, 1) == 0) begin r[19] = 1'b0; r[24] = 1'b0; r[11] = 1'b0; end
    if (r[6:0] == 7'h67 && $urandom_range(0, 1) == 0) r[14:12] = 3'b000;
    return r;
  endfunction

  // output monitor: a packet transfers when valid and ready are both high
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid4 && o_ready) begin
        if (q4.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb4_unexpected: got packet pc %0h, required no packet", o_pc4);
        end else check("sb4_pkt", 128'(act4), 128'(q4.pop_front()));
      end
      if (o_valid5 && o_ready) begin
        if (q5.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb5_unexpected: got packet pc %0h, required no packet", o_pc5);
        end else check("sb5_pkt", 128'(act5), 128'(q5.pop_front()));
      end
    end
  end

  // input-side predictor, runs after the output monitor in the same cycle
  always @(negedge clk) begin
    #1;
    if (rst || i_flush) begin
      q4.delete();
      q5.delete();
    end else begin
      if (i_valid && i_ready4) q4.push_back(ref_dec(i_inst, i_pc, 4));
      if (i_valid && i_ready5) q5.push_back(ref_dec(i_inst, i_pc, 5));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    i_valid = v; i_inst = inst; i_pc = pc;
  endtask

  initial begin
    rst = 1'b1; i_valid = 0; i_inst = 0; i_pc = 0; i_flush = 0; o_ready = 1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_o_valid", 128'(o_valid4), 128'(0));
    check("reset_i_ready", 128'(i_ready4), 128'(1));
    check("reset_o_imm", 128'(o_imm4), 128'(0));

    // addi x1,x0,5
    drive(1, 32'h0050_0093, 32'h8000_0000);
    step();
    drive(0, 0, 0);
    check("addi_latency_valid", 128'(o_valid4), 128'(1));
    check("addi_rdidx", 128'(o_rdidx4), 128'(1));
    check("addi_rdwen", 128'(o_rdwen4), 128'(1));
    check("addi_imm", 128'(o_imm4), 128'(5));
    check("addi_op_sel", 128'({o_op1_sel4, o_op2_sel4, o_alu_op4}), 128'({2'd0, 2'd1, 4'd0}));
    step();

    // sub then lui against a stalled consumer
    o_ready = 0;
    drive(1, 32'h4020_81b3, 32'h8000_0004);
    step();
    check("skid_i_ready_1st", 128'(i_ready4), 128'(1));
    drive(1, 32'h1234_52b7, 32'h8000_0008);
    step();
    drive(0, 0, 0);
    check("skid_i_ready_drop", 128'(i_ready4), 128'(0));
    check("skid_head_sub", 128'(o_alu_op4), 128'(1));
    step();
    o_ready = 1;
    step();
    check("skid_lui_imm", 128'(o_imm4), 128'(32'h1234_5000));
    check("skid_lui_op1", 128'(o_op1_sel4), 128'(2));
    check("skid_i_ready_back", 128'(i_ready4), 128'(1));
    step();
    check("skid_drained", 128'(o_valid4), 128'(0));

    // fill both entries, then flush while stalled
    o_ready = 0;
    drive(1, 32'h0050_0093, 32'h100);
    step();
    drive(1, 32'h0020_8133, 32'h104);
    step();
    check("flush_pre_full", 128'(i_ready4), 128'(0));
    drive(1, 32'h0030_0193, 32'h108);
    i_flush = 1;
    step();
    i_flush = 0;
    drive(0, 0, 0);
    check("flush_o_valid", 128'(o_valid4), 128'(0));
    check("flush_i_ready", 128'(i_ready4), 128'(1));
    o_ready = 1;
    drive(1, 32'h0050_0093, 32'h10c);
    i_flush = 1;
    step();
    i_flush = 0;
    drive(0, 0, 0);
    check("flush_drops_input", 128'(o_valid4), 128'(0));

    // add x16,x0,x0: illegal on RV32E, legal on RV32I
    drive(1, 32'h0000_0833, 32'h200);
    step();
    drive(0, 0, 0);
    check("rv32e_x16_illegal", 128'(o_illegal4), 128'(1));
    check("rv32e_x16_rdwen", 128'(o_rdwen4), 128'(0));
    check("rv32i_x16_legal", 128'(o_illegal5), 128'(0));
    check("rv32i_x16_rdidx", 128'(o_rdidx5), 128'(16));

    drive(1, 32'h0010_0073, 32'h204);
    step();
    check("ebreak", 128'({o_ebreak4, o_ecall4, o_illegal4}), 128'(3'b100));
    drive(1, 32'h0000_a0e7, 32'h208);
    step();
    check("jalr_bad_f3", 128'(o_illegal4), 128'(1));

    for (int k = 0; k < 8; k++) begin
      drive(1, 32'h0000_0013, 32'h300 + 32'(4 * k));
      step();
      check("stream_rate", 128'({o_valid4, i_ready4, o_pc4}), 128'({2'b11, 32'h300 + 32'(4 * k)}));
    end
    drive(0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, gen_inst(), $urandom() & 32'hffff_fffc);
      o_ready = $urandom_range(0, 3) != 0;
      i_flush = $urandom_range(0, 39) == 0;
      step();
    end
    drive(0, 0, 0);
    i_flush = 0;
    o_ready = 1;
    repeat (4) step();
    check("drain_q4_empty", 128'(q4.size()), 128'(0));
    check("drain_q5_empty", 128'(q5.size()), 128'(0));

    // asynchronous reset while both entries are occupied
    o_ready = 0;
    drive(1, 32'h0050_0093, 32'h400);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_o_valid", 128'(o_valid4), 128'(0));
    check("async_rst_i_ready", 128'(i_ready4), 128'(1));
    check("async_rst_o_imm", 128'(o_imm4), 128'(0));
    drive(0, 0, 0);
    step();
    rst = 1'b0;
    o_ready = 1;
    step();
    check("post_rst_o_valid", 128'(o_valid5), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
